z80_bus_master: RTL and testbench
=================================

Z80_BUS_MASTER -- requirements
Module: z80_bus_master

Interface
REQ-001 SHALL have parameter HALFCYCLE, default 100: eclk cycles per half period of the generated Z80 clk (minimum 2).
REQ-002 SHALL have ports: eclk  in  1  system clock, the only clock; reset_b  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: req_valid in 1 request strobe; req_ready out 1 idle/accepting; req_type in 3 (0 opcode fetch, 1 mem read, 2 mem write, 3 io read, 4 io write; 5-7 ignored, never accepted); req_addr in 16; req_wdata in 8.
REQ-004 SHALL have ports: resp_valid out 1 one-eclk completion pulse; resp_rdata out 8 read data.
REQ-005 SHALL have ports: clk out 1 Z80 clock; ab out 16; db_o out 8; db_oe out 1; db_i in 8; _wait in 1; _mreq, _iorq, _rd, _wr, _m1, _rfsh out 1 each, active low.

Function
REQ-006 SHALL free-run clk from reset, toggling every HALFCYCLE eclk cycles; a T-state SHALL start on a clk rising edge, and clk SHALL rise first HALFCYCLE cycles after reset release.
REQ-007 SHALL accept a request when req_valid & req_ready on an eclk edge; req_ready SHALL fall on acceptance, and inputs SHALL be latched then.
REQ-008 SHALL start T1 at the first clk rising edge after acceptance; with no request, T-states SHALL be idle: strobes high, db_oe 0, ab holding its last value.
REQ-009 SHALL use states IDLE, T1, T2, TWA (automatic IO wait), TW, T3, T4; every transition SHALL occur on a clk rising edge.
REQ-010 Opcode fetch: T1 rise ab=addr, _m1 low; T1 fall _mreq,_rd low; T2 fall sample _wait; T3 rise latch db_i, _mreq,_rd,_m1 high, ab={8'h00,1'b0,R[6:0]}, _rfsh low; T3 fall _mreq low; T4 fall _mreq high; end of T4 _rfsh high; R[6:0] SHALL then increment mod 128 (bit 7 stays 0).
REQ-011 Mem read: T1 rise ab; T1 fall _mreq,_rd low; T2 fall sample _wait; T3 fall latch db_i, _mreq,_rd high; ends at end of T3.
REQ-012 Mem write: T1 rise ab; T1 fall _mreq low, db_o=wdata, db_oe 1; T2 fall _wr low; T3 fall _mreq,_wr high; db_oe SHALL fall at end of T3.
REQ-013 IO read/write: T1 rise ab; T2 rise _iorq and _rd (read) or _wr (write) low, db_oe 1 for write; TWA always inserted; _wait sampled at TWA fall; T3 fall latch db_i (read) and strobes high; ends at end of T3.
REQ-014 _wait low at a sampling point SHALL insert one TW; _wait SHALL be resampled at each TW fall, so waits are unbounded; during TW all outputs SHALL hold.
REQ-015 SHALL pulse resp_valid in the eclk at which the final T-state ends; resp_rdata SHALL update only for read types and hold until the next read; req_ready SHALL rise in that same eclk.
REQ-016 A request accepted in the resp_valid eclk SHALL start T1 at the next clk rising edge (min one idle T-state between cycles).
REQ-017 At most one of _mreq/_iorq SHALL be low, and _rd and _wr SHALL never be low together.

Reset
REQ-018 On reset_b low, immediately: clk 0, ab 0, db_o 0, db_oe 0, all strobes 1, req_ready 1, resp_valid 0, resp_rdata 0, R 0, state IDLE, divider 0.
REQ-019 Reset mid-cycle SHALL abort the cycle with no resp_valid; the request is discarded.

Configuration
REQ-020 Macro Z80BM_REFRESH_EN defined: opcode fetch per REQ-010.
REQ-021 Macro undefined: fetch ends at end of T3 (no T4); at T3 rise, latch data, _mreq,_rd,_m1 high, ab holds fetch address; _rfsh constant 1; no R counter.

Verification
REQ-022 HALFCYCLE=2, mem read 0x1234, db_i=0xA5, _wait=1 -> _mreq/_rd low T1 fall..T3 fall, resp_rdata=0xA5, resp_valid once, 3 T-states.
REQ-023 Mem write 0x8000 data 0x5A -> db_o=0x5A, db_oe 1 T1 fall..end T3, _wr low T2 fall..T3 fall, _rd never low.
REQ-024 IO read 0x00AB, _wait low for 2 samples, db_i=0xBF -> T1,T2,TWA,TW,TW,T3; resp_rdata=0xBF.
REQ-025 130 fetches with Z80BM_REFRESH_EN -> refresh ab low byte 0x00..0x7F then wraps to 0x00, 0x01; _rfsh low T3 rise..T4 end; without macro, _rfsh constant 1, 3 T-states/fetch.
REQ-026 Request with resp_valid back-to-back -> exactly one idle T-state; reset_b low during T2 -> strobes high same eclk, no resp_valid; req_type 6 -> req_ready stays 1, no bus activity.

Source files
------------

// File: rtl/z80_bus_master.sv
// z80_bus_master: generates a free-running Z80 clock from eclk and runs one
// Z80 bus cycle per accepted request (opcode fetch, memory read/write, IO read/write).
// Define Z80BM_REFRESH_EN to add the T4 refresh phase and the R counter to opcode fetches.
module z80_bus_master #(
  parameter int unsigned HALFCYCLE = 100
) (
  input  logic        eclk,
  input  logic        reset_b,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_type,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        resp_valid,
  output logic [7:0]  resp_rdata,
  output logic        clk,
  output logic [15:0] ab,
  output logic [7:0]  db_o,
  output logic        db_oe,
  input  logic [7:0]  db_i,
  input  logic        _wait,
  output logic        _mreq,
  output logic        _iorq,
  output logic        _rd,
  output logic        _wr,
  output logic        _m1,
  output logic        _rfsh
);

  localparam int unsigned DivW = $clog2(HALFCYCLE);
  localparam logic [DivW-1:0] DivLast = DivW'(HALFCYCLE - 1);

  localparam logic [2:0] TypFetch = 3'd0;
  localparam logic [2:0] TypMemRd = 3'd1;
  localparam logic [2:0] TypMemWr = 3'd2;
  localparam logic [2:0] TypIoRd  = 3'd3;
  localparam logic [2:0] TypIoWr  = 3'd4;

`ifdef Z80BM_REFRESH_EN
  localparam bit RefreshEn = 1'b1;
`else
  localparam bit RefreshEn = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StT1, StT2, StTwa, StTw, StT3, StT4} state_e;

  state_e          state;
  logic [DivW-1:0] div;
  logic [2:0]      cyc_type;
  logic [15:0]     cyc_addr;
  logic [7:0]      cyc_wdata;
  logic            wait_n;
`ifdef Z80BM_REFRESH_EN
  logic [6:0]      r;
`endif

  logic rise_evt, fall_evt;
  logic is_fetch, is_io, is_read, is_wr;
  logic enter_t3, last_t;

  // clk edges happen on the same eclk edge as the registered bus outputs change
  assign rise_evt = (div == DivLast) && !clk;
  assign fall_evt = (div == DivLast) && clk;

  assign is_fetch = (cyc_type == TypFetch);
  assign is_io    = (cyc_type == TypIoRd) || (cyc_type == TypIoWr);
  assign is_read  = (cyc_type == TypFetch) || (cyc_type == TypMemRd) || (cyc_type == TypIoRd);
  assign is_wr    = (cyc_type == TypMemWr) || (cyc_type == TypIoWr);

  // wait_n holds the _wait sample taken at the fall of the state now ending
  assign enter_t3 = rise_evt && wait_n &&
                    ((state == StT2 && !is_io) || state == StTwa || state == StTw);
  assign last_t   = (state == StT3 && !(is_fetch && RefreshEn)) || state == StT4;

`ifndef Z80BM_REFRESH_EN
  assign _rfsh = 1'b1;
`endif

  // Z80 clock divider: clk toggles every HALFCYCLE eclk cycles
  always_ff @(posedge eclk or negedge reset_b) begin
    if (!reset_b) begin
      div <= '0;
      clk <= 1'b0;
    end else if (div == DivLast) begin
      div <= '0;
      clk <= ~clk;
    end else begin
      div <= div + DivW'(1);
    end
  end

  // Bus cycle FSM: state moves on clk rise, strobes change on clk rise or fall
  always_ff @(posedge eclk or negedge reset_b) begin
    if (!reset_b) begin
      state      <= StIdle;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 8'h00;
      ab         <= 16'h0000;
      db_o       <= 8'h00;
      db_oe      <= 1'b0;
      _mreq      <= 1'b1;
      _iorq      <= 1'b1;
      _rd        <= 1'b1;
      _wr        <= 1'b1;
      _m1        <= 1'b1;
      cyc_type   <= TypFetch;
      cyc_addr   <= 16'h0000;
      cyc_wdata  <= 8'h00;
      wait_n     <= 1'b1;
`ifdef Z80BM_REFRESH_EN
      _rfsh      <= 1'b1;
      r          <= 7'd0;
`endif
    end else begin
      resp_valid <= 1'b0;

      // Types 5-7 are never accepted
      if (req_valid && req_ready && (req_type <= TypIoWr)) begin
        req_ready <= 1'b0;
        cyc_type  <= req_type;
        cyc_addr  <= req_addr;
        cyc_wdata <= req_wdata;
      end

      if (rise_evt) begin
        unique case (state)
          StIdle: begin
            // req_ready low in idle means a request is waiting for its T1
            if (!req_ready) begin
              state <= StT1;
              ab    <= cyc_addr;
              if (is_fetch) _m1 <= 1'b0;
            end
          end
          StT1: begin
            state <= StT2;
            if (is_io) begin
              _iorq <= 1'b0;
              if (is_wr) begin
                _wr   <= 1'b0;
                db_o  <= cyc_wdata;
                db_oe <= 1'b1;
              end else begin
                _rd <= 1'b0;
              end
            end
          end
          StT2: begin
            if (is_io) state <= StTwa;
            else       state <= wait_n ? StT3 : StTw;
          end
          StTwa, StTw: state <= wait_n ? StT3 : StTw;
          StT3: if (is_fetch && RefreshEn) state <= StT4;
          default: ;
        endcase

        if (enter_t3 && is_fetch) begin
          resp_rdata <= db_i;
          _mreq      <= 1'b1;
          _rd        <= 1'b1;
          _m1        <= 1'b1;
`ifdef Z80BM_REFRESH_EN
          ab         <= {9'h000, r};
          _rfsh      <= 1'b0;
`endif
        end

        if (last_t) begin
          state      <= StIdle;
          resp_valid <= 1'b1;
          req_ready  <= 1'b1;
          db_oe      <= 1'b0;
`ifdef Z80BM_REFRESH_EN
          if (state == StT4) begin
            _rfsh <= 1'b1;
            r     <= r + 7'd1;
          end
`endif
        end
      end

      if (fall_evt) begin
        unique case (state)
          StT1: begin
            if (!is_io) begin
              _mreq <= 1'b0;
              if (is_wr) begin
                db_o  <= cyc_wdata;
                db_oe <= 1'b1;
              end else begin
                _rd <= 1'b0;
              end
            end
          end
          StT2: begin
            wait_n <= _wait;
            if (is_wr && !is_io) _wr <= 1'b0;
          end
          StTwa, StTw: wait_n <= _wait;
          StT3: begin
            if (!is_fetch) begin
              if (is_read) resp_rdata <= db_i;
              _mreq <= 1'b1;
              _iorq <= 1'b1;
              _rd   <= 1'b1;
              _wr   <= 1'b1;
            end
`ifdef Z80BM_REFRESH_EN
            else begin
              _mreq <= 1'b0;
            end
`endif
          end
          StT4: _mreq <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_z80_bus_master.sv
// tb_z80_bus_master: scoreboard bench for z80_bus_master with HALFCYCLE=2.
// Builds with or without Z80BM_REFRESH_EN; expectations follow the macro.
module tb_z80_bus_master;

  localparam int unsigned H = 2;
  localparam int WLimit = 400;

`ifdef Z80BM_REFRESH_EN
  localparam bit RefEn = 1'b1;
`else
  localparam bit RefEn = 1'b0;
`endif

  logic        eclk = 1'b0;
  logic        reset_b = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_type = 3'd0;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  req_wdata = 8'h00;
  logic        resp_valid;
  logic [7:0]  resp_rdata;
  logic        zclk;
  logic [15:0] ab;
  logic [7:0]  db_o;
  logic        db_oe;
  logic [7:0]  db_i = 8'h00;
  logic        wait_b = 1'b1;
  logic        mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b;

  z80_bus_master #(.HALFCYCLE(H)) dut (
    .eclk      (eclk),
    .reset_b   (reset_b),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_type  (req_type),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .clk       (zclk),
    .ab        (ab),
    .db_o      (db_o),
    .db_oe     (db_oe),
    .db_i      (db_i),
    ._wait     (wait_b),
    ._mreq     (mreq_b),
    ._iorq     (iorq_b),
    ._rd       (rd_b),
    ._wr       (wr_b),
    ._m1       (m1_b),
    ._rfsh     (rfsh_b)
  );

  always #5 eclk = ~eclk;

  typedef struct {
    logic [2:0]  typ;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic [15:0] rfsh_ab;
    int tst, mreq, iorq, rd, wr, oe, m1, rfsh;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mdl_rdata = 8'h00;
  logic [6:0] mdl_r = 7'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: everything sampled on the falling eclk edge, away from DUT updates
  bit   clk_prev = 1'b0, rdy_prev = 1'b1, resp_prev = 1'b0, active = 1'b0;
  int   rise_cnt = 0, fall_cnt = 0;
  int   t_rises, c_mreq, c_iorq, c_rd, c_wr, c_oe, c_m1, c_rfsh;
  logic [15:0] ab_seen, rab_seen;
  logic [7:0]  wr_seen;
  bit   ab_got, rab_got, viol;

  always @(negedge eclk) begin : mon
    bit rose, fell;
    if (!reset_b) begin
      active    = 1'b0;
      clk_prev  = zclk;
      rdy_prev  = req_ready;
      resp_prev = 1'b0;
    end else begin
      rose = zclk && !clk_prev;
      fell = !zclk && clk_prev;
      if (rose) rise_cnt++;
      if (fell) fall_cnt++;
      if (resp_prev) check_eq("resp_one_eclk", resp_valid, 0);
      if (rdy_prev && !req_ready) begin
        active = 1'b1;
        t_rises = 0; c_mreq = 0; c_iorq = 0; c_rd = 0; c_wr = 0;
        c_oe = 0; c_m1 = 0; c_rfsh = 0;
        ab_got = 1'b0; rab_got = 1'b0; viol = 1'b0;
        ab_seen = 16'h0; rab_seen = 16'hFFFF; wr_seen = 8'h00;
      end else if (active) begin
        if (rose) t_rises++;
        if (!mreq_b) c_mreq++;
        if (!iorq_b) c_iorq++;
        if (!rd_b) c_rd++;
        if (!wr_b) begin
          c_wr++;
          wr_seen = db_oe ? db_o : 8'hxx;
        end
        if (db_oe) c_oe++;
        if (!m1_b) c_m1++;
        if (!rfsh_b) c_rfsh++;
        if ((!mreq_b && !iorq_b) || (!rd_b && !wr_b)) viol = 1'b1;
        if (!ab_got && (!mreq_b || !iorq_b) && rfsh_b) begin
          ab_got = 1'b1;
          ab_seen = ab;
        end
        if (!rab_got && !rfsh_b) begin
          rab_got = 1'b1;
          rab_seen = ab;
        end
      end
      if (resp_valid) begin
        check_eq("resp_expected", 32'(sb.size()), 1);
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          check_eq("tstates", 32'(t_rises - 1), 32'(cur.tst));
          check_eq("rdata", resp_rdata, cur.rdata);
          check_eq("mreq_low", 32'(c_mreq), 32'(cur.mreq));
          check_eq("iorq_low", 32'(c_iorq), 32'(cur.iorq));
          check_eq("rd_low", 32'(c_rd), 32'(cur.rd));
          check_eq("wr_low", 32'(c_wr), 32'(cur.wr));
          check_eq("db_oe_high", 32'(c_oe), 32'(cur.oe));
          check_eq("m1_low", 32'(c_m1), 32'(cur.m1));
          check_eq("rfsh_low", 32'(c_rfsh), 32'(cur.rfsh));
          check_eq("cycle_addr", ab_seen, cur.addr);
          check_eq("strobe_exclusive", viol, 0);
          if (cur.typ == 3'd2 || cur.typ == 3'd4) check_eq("write_data", wr_seen, cur.wdata);
          if (cur.typ == 3'd0 && RefEn) check_eq("refresh_addr", rab_seen, cur.rfsh_ab);
        end
        active = 1'b0;
      end
      clk_prev  = zclk;
      rdy_prev  = req_ready;
      resp_prev = resp_valid;
    end
  end

  // One request: push expectation, drive, shape _wait, wait for completion
  task automatic do_req(input logic [2:0] typ, input logic [15:0] addr, input logic [7:0] wd,
                        input logic [7:0] din, input int nwait);
    exp_t e;
    int k, r0, f0, s, hw;
    k = 0;
    while (!req_ready && k < WLimit) begin @(negedge eclk); #1; k++; end
    hw = 2 * H * nwait;
    e.typ = typ; e.addr = addr; e.wdata = wd; e.rfsh_ab = 16'hFFFF;
    e.mreq = 0; e.iorq = 0; e.rd = 0; e.wr = 0; e.oe = 0; e.m1 = 0; e.rfsh = 0;
    case (typ)
      3'd0: begin
        e.m1 = 4 * H + hw;
        e.rd = 3 * H + hw;
        if (RefEn) begin
          e.tst = 4 + nwait; e.mreq = 5 * H + hw; e.rfsh = 4 * H;
          e.rfsh_ab = {9'h000, mdl_r};
          mdl_r = mdl_r + 7'd1;
        end else begin
          e.tst = 3 + nwait; e.mreq = 3 * H + hw;
        end
      end
      3'd1: begin e.tst = 3 + nwait; e.mreq = 4 * H + hw; e.rd = 4 * H + hw; end
      3'd2: begin
        e.tst = 3 + nwait; e.mreq = 4 * H + hw; e.wr = 2 * H + hw; e.oe = 5 * H + hw;
      end
      3'd3: begin e.tst = 4 + nwait; e.iorq = 5 * H + hw; e.rd = 5 * H + hw; end
      default: begin
        e.tst = 4 + nwait; e.iorq = 5 * H + hw; e.wr = 5 * H + hw; e.oe = 6 * H + hw;
      end
    endcase
    if (typ == 3'd0 || typ == 3'd1 || typ == 3'd3) mdl_rdata = din;
    e.rdata = mdl_rdata;
    sb.push_back(e);

    db_i = din; wait_b = 1'b1;
    req_valid = 1'b1; req_type = typ; req_addr = addr; req_wdata = wd;
    @(negedge eclk); #1;
    req_valid = 1'b0;
    if (nwait > 0) begin
      // Hold _wait low from T1 until nwait sampling falls have passed
      wait_b = 1'b0;
      s = (typ == 3'd3 || typ == 3'd4) ? 3 : 2;
      r0 = rise_cnt; k = 0;
      while (rise_cnt == r0 && k < WLimit) begin @(negedge eclk); #1; k++; end
      f0 = fall_cnt; k = 0;
      while (fall_cnt < f0 + s + nwait - 1 && k < WLimit) begin @(negedge eclk); #1; k++; end
      wait_b = 1'b1;
    end
    k = 0;
    while (!resp_valid && k < WLimit) begin @(negedge eclk); #1; k++; end
    check_eq("resp_seen", resp_valid, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_strobes"}, {26'd0, mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b}, 32'h3F);
    check_eq({tag, "_clk_oe_resp"}, {29'd0, zclk, db_oe, resp_valid}, 0);
    check_eq({tag, "_ready"}, req_ready, 1);
    check_eq({tag, "_ab_db"}, {ab, db_o}, 0);
    check_eq({tag, "_rdata"}, resp_rdata, 0);
  endtask

  task automatic release_reset();
    int k;
    @(negedge eclk); #1;
    reset_b = 1'b1;
    k = 0;
    while (!zclk && k < 50) begin @(negedge eclk); k++; end
    check_eq("clk_first_rise", 32'(k), H);
  endtask

  initial begin
    int k;
    bit rdy_all, bus_act;
    #3 reset_b = 1'b0;
    #1 check_reset_state("reset");
    repeat (3) @(negedge eclk);
    release_reset();

    do_req(3'd1, 16'h1234, 8'h00, 8'hA5, 0);
    repeat (5) @(negedge eclk);
    #1 do_req(3'd2, 16'h8000, 8'h5A, 8'h00, 0);
    do_req(3'd3, 16'h00AB, 8'h00, 8'hBF, 2);
    do_req(3'd4, 16'h00CD, 8'h3C, 8'h11, 0);
    repeat (7) @(negedge eclk);
    #1 do_req(3'd1, 16'hFFFF, 8'h00, 8'h7E, 1);
    do_req(3'd0, 16'h0100, 8'h00, 8'hC3, 1);
    do_req(3'd2, 16'h0001, 8'hE7, 8'h00, 2);

    // Unsupported type must never be accepted nor touch the bus
    rdy_all = 1'b1; bus_act = 1'b0;
    req_valid = 1'b1; req_type = 3'd6; req_addr = 16'h5555;
    for (int i = 0; i < 8 * H; i++) begin
      @(negedge eclk);
      rdy_all &= req_ready;
      if (!mreq_b || !iorq_b || !rd_b || !wr_b || !m1_b || db_oe) bus_act = 1'b1;
    end
    #1 req_valid = 1'b0;
    check_eq("type6_ready", rdy_all, 1);
    check_eq("type6_bus_idle", bus_act, 0);

    for (int i = 0; i < 130; i++) do_req(3'd0, 16'h2000 + 16'(i), 8'h00, 8'(i * 3), 0);

    // Reset in the middle of T2 of a memory read: no response may follow
    k = 0;
    while (!req_ready && k < WLimit) begin @(negedge eclk); #1; k++; end
    req_valid = 1'b1; req_type = 3'd1; req_addr = 16'h4444; db_i = 8'h66;
    @(negedge eclk); #1;
    req_valid = 1'b0;
    k = rise_cnt;
    while (rise_cnt < k + 2 && rise_cnt < k + WLimit) @(negedge eclk);
    #1 check_eq("mreq_before_reset", mreq_b, 0);
    #1 reset_b = 1'b0;
    #1 check_reset_state("midcycle_reset");
    mdl_rdata = 8'h00;
    mdl_r = 7'd0;
    repeat (4) @(negedge eclk);
    release_reset();
    repeat (20) @(negedge eclk);
    #1 do_req(3'd0, 16'h3000, 8'h00, 8'h42, 0);
    do_req(3'd1, 16'h4321, 8'h00, 8'h99, 0);
    repeat (10) @(negedge eclk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
